key_step_gen: RTL and testbench
===============================

Name: key_step_gen

Overview:
- Front-end stage that turns a raw, bouncing push-button into clean step pulses for the up/down counter stage.
- Chain: board KEY → key_step_gen → STEP (count enable) into the counter that feeds the 7-segment encoder.
- Pipeline: 2-FF synchroniser, stable-window debouncer, then a press/auto-repeat FSM.
- Holding the key produces one step, then after a delay a steady stream of steps.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples needed to accept a level change (20 ms at 50 MHz).
- REPEAT_DELAY, 25000000, cycles from the first STEP to the first auto-repeat STEP (500 ms).
- REPEAT_PERIOD, 6250000, cycles between successive auto-repeat STEPs (125 ms).
- KEY_ACTIVE_LOW, 1, 1 means KEY_RAW=0 is "pressed"; 0 means KEY_RAW=1 is "pressed".

Ports:
- CLK  in  1  system clock (50 MHz board clock).
- RST_N  in  1  asynchronous active-low reset.
- KEY_RAW  in  1  raw button pin; asynchronous to CLK.
- KEY_LEVEL  out  1  debounced key state, 1 = pressed.
- STEP  out  1  single-cycle step pulse.
- REPEATING  out  1  high while the auto-repeat stream is active.

Behaviour:
- Interface: one clock, CLK; reset RST_N is asynchronous, active-low. All flops clear on RST_N=0 regardless of CLK.
- Reset values:
  - KEY_LEVEL=0, STEP=0, REPEATING=0.
  - Both synchroniser flops = released level (1 if KEY_ACTIVE_LOW, else 0).
  - All counters = 0; FSM = IDLE.
- Synchroniser: KEY_RAW passes through 2 flops, then is normalised to pressed = 1 (inverted when KEY_ACTIVE_LOW).
- Debouncer:
  - Counter increments each cycle the normalised sample differs from KEY_LEVEL; it clears on any cycle the sample equals KEY_LEVEL.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, KEY_LEVEL toggles on the next edge and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES is fully rejected.
- Latency: a clean step on KEY_RAW first sampled at edge k gives KEY_LEVEL change at edge k+2+DEBOUNCE_CYCLES-1.
- FSM states and transitions:
  - IDLE: on KEY_LEVEL 0→1, assert STEP for one cycle, clear the timer, go to HOLD.
  - HOLD: timer counts. When the timer reaches REPEAT_DELAY-1, assert STEP, clear the timer, set REPEATING=1, go to REPEAT.
  - REPEAT: timer counts. Every time it reaches REPEAT_PERIOD-1, assert STEP and clear the timer.
  - HOLD or REPEAT with KEY_LEVEL=0: go to IDLE the same edge KEY_LEVEL falls is observed. Timer cleared, REPEATING=0, no STEP generated on release.
- STEP is registered and is never high for two consecutive cycles when REPEAT_PERIOD≥2.
- Timer width: $clog2 of max(REPEAT_DELAY, REPEAT_PERIOD). Debounce counter width: $clog2(DEBOUNCE_CYCLES). No wrap-around is possible, because counters clear at terminal count.
- Simultaneous events: a release observed on the same cycle the timer hits terminal count gives release priority (no STEP, go to IDLE).
- Reset mid-operation (including mid-repeat): immediate return to reset values. Once RST_N deasserts, a key already held must complete a full DEBOUNCE_CYCLES window before STEP fires.
- Parameter legality (elaboration assertion): DEBOUNCE_CYCLES≥2, REPEAT_DELAY≥2, REPEAT_PERIOD≥2.

Decomposition:
- Shared package key_pkg holds:
  - typedef enum logic[1:0] {IDLE, HOLD, REPEAT} key_state_t.
  - Default constants DEF_DEBOUNCE, DEF_REPEAT_DELAY, DEF_REPEAT_PERIOD for a 50 MHz clock.
- One sub-module, key_debouncer: synchroniser, polarity normalisation and stable-window counter, outputting KEY_LEVEL.
- The FSM and repeat timer stay in key_step_gen.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, KEY_ACTIVE_LOW=1):
- Reset → RST_N=0 mid-cycle with KEY_RAW=0 → KEY_LEVEL/STEP/REPEATING=0 immediately. After release, KEY_LEVEL=1 only after 2+4 clean cycles.
- Single press → KEY_RAW 1→0 held 8 cycles then released → exactly one STEP, in the cycle KEY_LEVEL rises. KEY_LEVEL falls 5 cycles after release. REPEATING never set.
- Bounce rejection → KEY_RAW toggles 0,1,0,1 each 2 cycles, then stays 1 → KEY_LEVEL stays 0, zero STEPs.
- Auto-repeat → KEY_RAW=0 held 30 cycles → STEPs at press cycle P, P+10, P+13, P+16, … (P+28 last before release). REPEATING=1 from P+10.
- Release at terminal count → KEY_LEVEL falls on the cycle the repeat timer hits 2 → no STEP that cycle, state IDLE, REPEATING=0.
- Reset mid-repeat → RST_N pulsed low at P+14 with key still held → all outputs 0. Next STEP only 6 cycles after RST_N deasserts.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and board-default timing constants for the push-button step generator.
// The defaults assume a 50 MHz clock.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } key_state_t;

    localparam int DEF_DEBOUNCE      = 1000000;   // 20 ms
    localparam int DEF_REPEAT_DELAY  = 25000000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD = 6250000;   // 125 ms

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_step_gen_if.sv
// Key-side bus of the step generator: raw pin in; debounced level, step pulse and repeat flag out.
interface key_step_gen_if;
    logic KEY_RAW;
    logic KEY_LEVEL;
    logic STEP;
    logic REPEATING;

    modport master (output KEY_RAW, input KEY_LEVEL, input STEP, input REPEATING);
    modport slave  (input KEY_RAW, output KEY_LEVEL, output STEP, output REPEATING);
endinterface

// File: rtl/key_debouncer.sv
// Two-flop synchroniser, polarity normalisation and stable-window debouncer.
// key_level_next exposes the level the register takes on the coming edge.
module key_debouncer
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic key_raw,
    output logic key_level,
    output logic key_level_next
);

    localparam int                CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic              RELEASED = KEY_ACTIVE_LOW;

    logic [1:0]       sync_reg;
    logic             pressed;
    logic             level_reg;
    logic             level_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // Synchroniser idles at the released pin level so reset never looks like a press.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_reg <= {RELEASED, RELEASED};
        end else begin
            sync_reg <= {sync_reg[0], key_raw};
        end
    end

    assign pressed = KEY_ACTIVE_LOW ? ~sync_reg[1] : sync_reg[1];

    // The counter only survives while every sample disagrees with the current level.
    always_comb begin
        cnt_next   = '0;
        level_next = level_reg;
        if (pressed != level_reg) begin
            if (cnt_reg == CNT_LAST) begin
                level_next = ~level_reg;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            level_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            level_reg <= level_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign key_level      = level_reg;
    assign key_level_next = level_next;

endmodule

// File: rtl/key_step_gen.sv
// Push-button front end: debounced key level plus a press/auto-repeat step pulse stream
// that drives the counter's count enable.
module key_step_gen
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic           CLK,
    input  logic           RST_N,
    key_step_gen_if.slave  key_bus
);

    localparam int               TMR_MAX    = max_int(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int               TMR_W      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_params
        $error("key_step_gen: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must all be >= 2");
    end

    logic             key_level;
    logic             key_level_next;
    logic             key_rise;
    key_state_t       state_reg;
    key_state_t       state_next;
    logic [TMR_W-1:0] timer_reg;
    logic [TMR_W-1:0] timer_next;
    logic             step_reg;
    logic             step_next;
    logic             repeating_reg;
    logic             repeating_next;

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
    ) u_debouncer (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .key_raw        (key_bus.KEY_RAW),
        .key_level      (key_level),
        .key_level_next (key_level_next)
    );

    // The FSM follows the debouncer's next level so its reaction lands on the same
    // edge as the KEY_LEVEL change (first STEP with the rise, return to IDLE with the fall).
    assign key_rise = key_level_next & ~key_level;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg     <= IDLE;
            timer_reg     <= '0;
            step_reg      <= 1'b0;
            repeating_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            step_reg      <= step_next;
            repeating_reg <= repeating_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (key_rise) state_next = HOLD;
            HOLD: begin
                if (!key_level_next) begin
                    state_next = IDLE;
                end else if (timer_reg == DELAY_LAST) begin
                    state_next = REPEAT;
                end
            end
            REPEAT:  if (!key_level_next) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Release is checked first so a release on a terminal-count cycle suppresses the step.
    always_comb begin
        timer_next     = '0;
        step_next      = 1'b0;
        repeating_next = 1'b0;
        case (state_reg)
            IDLE: begin
                step_next = key_rise;
            end
            HOLD: begin
                if (key_level_next) begin
                    if (timer_reg == DELAY_LAST) begin
                        step_next      = 1'b1;
                        repeating_next = 1'b1;
                    end else begin
                        timer_next = timer_reg + TMR_W'(1);
                    end
                end
            end
            REPEAT: begin
                if (key_level_next) begin
                    repeating_next = 1'b1;
                    if (timer_reg == PERIOD_LAST) begin
                        step_next = 1'b1;
                    end else begin
                        timer_next = timer_reg + TMR_W'(1);
                    end
                end
            end
            default: begin
                timer_next = '0;
            end
        endcase
    end

    assign key_bus.KEY_LEVEL = key_level;
    assign key_bus.STEP      = step_reg;
    assign key_bus.REPEATING = repeating_reg;

endmodule

// File: tb/tb_key_step_gen.sv
// Self-checking bench for key_step_gen: a window/arithmetic model checked every cycle,
// plus hand-computed edge positions for each directed scenario.
module tb_key_step_gen;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic CLK   = 1'b0;
    logic RST_N = 1'b1;

    key_step_gen_if kif ();

    key_step_gen #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .KEY_ACTIVE_LOW  (1'b1)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .key_bus (kif)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int gcyc  = 0;

    // Model state: edge count since reset, pressed samples, debounced level, press edge.
    int cyc;
    int p_edge;
    bit m_level, m_step, m_rep;
    bit raw_q[$];
    bit used_q[$];

    int step_log[$], rise_log[$], fall_log[$], rep_rise_log[$], rep_fall_log[$];
    logic prev_level = 1'b0;
    logic prev_rep   = 1'b0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s edge %0d: got %b, expected %b", name, gcyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int count_in(input int q[$], input int lo, input int hi);
        int n = 0;
        foreach (q[i]) if (q[i] > lo && q[i] <= hi) n++;
        return n;
    endfunction

    function automatic int first_after(input int q[$], input int t);
        foreach (q[i]) if (q[i] > t) return q[i];
        return -1;
    endfunction

    task automatic model_reset();
        cyc     = 0;
        p_edge  = 0;
        m_level = 1'b0;
        m_step  = 1'b0;
        m_rep   = 1'b0;
        raw_q   = '{1'b0, 1'b0};
        used_q.delete();
    endtask

    // Level flips once the last D synchronised samples all disagree with it; steps fall at
    // press edge P, then P+RD, P+RD+RP, ... while the level stays high.
    task automatic model_edge();
        bit used, lvl_next, all_diff;
        int d;
        cyc++;
        raw_q.push_front(!kif.KEY_RAW);
        used = raw_q[2];
        void'(raw_q.pop_back());
        used_q.push_front(used);
        if (used_q.size() > D) void'(used_q.pop_back());
        lvl_next = m_level;
        if (used_q.size() == D) begin
            all_diff = 1'b1;
            foreach (used_q[i]) if (used_q[i] == m_level) all_diff = 1'b0;
            if (all_diff) begin
                lvl_next = !m_level;
                used_q.delete();
            end
        end
        if (lvl_next && !m_level) begin
            p_edge = cyc;
            m_step = 1'b1;
            m_rep  = 1'b0;
        end else if (lvl_next) begin
            d      = cyc - p_edge;
            m_step = (d == RD) || (d > RD && ((d - RD) % RP) == 0);
            m_rep  = (d >= RD);
        end else begin
            m_step = 1'b0;
            m_rep  = 1'b0;
        end
        m_level = lvl_next;
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge RST_N);
            model_reset();
        end
    end

    initial begin
        forever begin
            @(posedge CLK);
            gcyc++;
            if (RST_N !== 1'b1) model_reset();
            else model_edge();
        end
    end

    // Per-cycle compare against the model, and event logging for the directed checks.
    initial begin
        forever begin
            @(negedge CLK);
            if (RST_N === 1'b1) begin
                check_bit("key_level", kif.KEY_LEVEL, m_level);
                check_bit("step", kif.STEP, m_step);
                check_bit("repeating", kif.REPEATING, m_rep);
            end else begin
                check_bit("rst_key_level", kif.KEY_LEVEL, 1'b0);
                check_bit("rst_step", kif.STEP, 1'b0);
                check_bit("rst_repeating", kif.REPEATING, 1'b0);
            end
            if (kif.STEP === 1'b1) step_log.push_back(gcyc);
            if (kif.KEY_LEVEL === 1'b1 && prev_level === 1'b0) rise_log.push_back(gcyc);
            if (kif.KEY_LEVEL === 1'b0 && prev_level === 1'b1) fall_log.push_back(gcyc);
            if (kif.REPEATING === 1'b1 && prev_rep === 1'b0) rep_rise_log.push_back(gcyc);
            if (kif.REPEATING === 1'b0 && prev_rep === 1'b1) rep_fall_log.push_back(gcyc);
            prev_level = kif.KEY_LEVEL;
            prev_rep   = kif.REPEATING;
        end
    end

    task automatic drive(input logic val, input int n);
        kif.KEY_RAW = val;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check_steps(input string name, input int p, input int lo, input int hi);
        int deltas[8] = '{0, 10, 13, 16, 19, 22, 25, 28};
        int got[$];
        foreach (step_log[i]) if (step_log[i] > lo && step_log[i] <= hi) got.push_back(step_log[i]);
        check_int({name, "_count"}, got.size(), 8);
        foreach (deltas[i]) begin
            if (i < got.size()) check_int($sformatf("%s_step%0d", name, i), got[i], p + deltas[i]);
        end
    endtask

    initial begin
        int base, p, r;
        kif.KEY_RAW = 1'b1;
        #2 RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_bit("init_level", kif.KEY_LEVEL, 1'b0);
        check_bit("init_step", kif.STEP, 1'b0);
        check_bit("init_rep", kif.REPEATING, 1'b0);
        RST_N = 1'b1;
        drive(1'b1, 5);

        // Asynchronous reset with the key held, then a held key after release.
        drive(1'b0, 10);
        check_bit("held_level_before_reset", kif.KEY_LEVEL, 1'b1);
        #2 RST_N = 1'b0;
        #1;
        check_bit("async_rst_level", kif.KEY_LEVEL, 1'b0);
        check_bit("async_rst_step", kif.STEP, 1'b0);
        check_bit("async_rst_rep", kif.REPEATING, 1'b0);
        repeat (2) @(posedge CLK);
        #3 RST_N = 1'b1;
        r = gcyc;
        repeat (9) @(posedge CLK);
        #1;
        check_int("rst_release_level_rise", first_after(rise_log, r), r + 6);
        check_int("rst_release_first_step", first_after(step_log, r), r + 6);
        drive(1'b1, 12);

        // Single press: one step with the rise, fall 5 edges after the release is sampled.
        base = gcyc;
        drive(1'b0, 8);
        drive(1'b1, 12);
        check_int("single_step_count", count_in(step_log, base, gcyc), 1);
        check_int("single_step_edge", first_after(step_log, base), base + 6);
        check_int("single_fall_edge", first_after(fall_log, base), base + 14);
        check_int("single_no_repeat", count_in(rep_rise_log, base, gcyc), 0);

        // Bounce shorter than the window is ignored.
        base = gcyc;
        drive(1'b0, 2);
        drive(1'b1, 2);
        drive(1'b0, 2);
        drive(1'b1, 12);
        check_int("bounce_steps", count_in(step_log, base, gcyc), 0);
        check_int("bounce_rises", count_in(rise_log, base, gcyc), 0);

        // Auto-repeat, 30-cycle hold.
        base = gcyc;
        drive(1'b0, 30);
        drive(1'b1, 12);
        p = base + 6;
        check_steps("repeat", p, base, gcyc);
        check_int("repeat_rep_rise", first_after(rep_rise_log, base), p + 10);
        check_int("repeat_fall", first_after(fall_log, base), p + 30);
        check_int("repeat_rep_fall", first_after(rep_fall_log, base), p + 30);

        // Release lands on a terminal-count edge: no step there.
        base = gcyc;
        drive(1'b0, 31);
        drive(1'b1, 12);
        p = base + 6;
        check_steps("term", p, base, gcyc);
        check_int("term_fall", first_after(fall_log, base), p + 31);
        check_int("term_no_step_after", count_in(step_log, p + 28, gcyc), 0);
        check_int("term_rep_fall", first_after(rep_fall_log, base), p + 31);

        // Reset in the middle of auto-repeat with the key still held.
        base = gcyc;
        kif.KEY_RAW = 1'b0;
        repeat (20) @(posedge CLK);
        #1;
        check_bit("midrep_repeating", kif.REPEATING, 1'b1);
        #2 RST_N = 1'b0;
        #1;
        check_bit("midrep_rst_level", kif.KEY_LEVEL, 1'b0);
        check_bit("midrep_rst_step", kif.STEP, 1'b0);
        check_bit("midrep_rst_rep", kif.REPEATING, 1'b0);
        repeat (2) @(posedge CLK);
        #3 RST_N = 1'b1;
        r = gcyc;
        repeat (8) @(posedge CLK);
        #1;
        check_int("midrep_next_step", first_after(step_log, r), r + 6);
        drive(1'b1, 12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
